// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: BCD seconds/minutes/hours advanced by a one-second tick,
// with a validated valid/ready load port and registered rollover strobes.
module clock_time_keeper #(
    parameter int HOURS_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hold,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic       load_ok,
    output logic       load_err,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       sec_carry,
    output logic       min_carry,
    output logic       day_pulse
);

    localparam bit         MODE_12    = (HOURS_PER_DAY == 12);
    localparam logic [7:0] HOUR_RESET = MODE_12 ? 8'h12 : 8'h00;
    localparam logic [7:0] HOUR_LAST  = MODE_12 ? 8'h12 : 8'h23;
    localparam logic [7:0] HOUR_FIRST = MODE_12 ? 8'h01 : 8'h00;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] max_tens);
        return (v[7:4] <= max_tens) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s);
        logic [6:0] hv;
        logic       hour_range;
        hv = 7'(h[7:4]) * 7'd10 + 7'(h[3:0]);
        if (MODE_12) begin
            hour_range = (hv >= 7'd1) && (hv <= 7'd12);
        end else begin
            hour_range = (hv <= 7'd23);
        end
        return bcd_ok(h, 4'd9) && bcd_ok(m, 4'd5) && bcd_ok(s, 4'd5) && hour_range;
    endfunction

    state_t     state_r;
    logic       load_ready_r;
    logic       load_ok_r;
    logic       load_err_r;
    logic [7:0] sec_r;
    logic [7:0] min_r;
    logic [7:0] hour_r;
    logic       sec_carry_r;
    logic       min_carry_r;
    logic       day_pulse_r;
    logic [7:0] cap_hour_r;
    logic [7:0] cap_min_r;
    logic [7:0] cap_sec_r;

    logic       handshake_s;
    logic       cap_ok_s;
    logic       sec_wrap_s;
    logic       min_wrap_s;
    logic       hour_wrap_s;
    logic [7:0] sec_next_s;
    logic [7:0] min_next_s;
    logic [7:0] hour_next_s;

    // Next-second time value and cascaded wrap conditions, plus load validation.
    always_comb begin
        sec_wrap_s  = (sec_r == 8'h59);
        min_wrap_s  = sec_wrap_s && (min_r == 8'h59);
        hour_wrap_s = min_wrap_s && (hour_r == HOUR_LAST);
        if (sec_wrap_s) begin
            sec_next_s = 8'h00;
        end else begin
            sec_next_s = bcd_inc(sec_r);
        end
        if (min_wrap_s) begin
            min_next_s = 8'h00;
        end else if (sec_wrap_s) begin
            min_next_s = bcd_inc(min_r);
        end else begin
            min_next_s = min_r;
        end
        if (hour_wrap_s) begin
            hour_next_s = HOUR_FIRST;
        end else if (min_wrap_s) begin
            hour_next_s = bcd_inc(hour_r);
        end else begin
            hour_next_s = hour_r;
        end
        handshake_s = load_valid && load_ready_r;
        cap_ok_s    = time_ok(cap_hour_r, cap_min_r, cap_sec_r);
    end

    // Control FSM, time registers and all registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_INIT;
            load_ready_r <= 1'b0;
            load_ok_r    <= 1'b0;
            load_err_r   <= 1'b0;
            sec_r        <= 8'h00;
            min_r        <= 8'h00;
            hour_r       <= HOUR_RESET;
            sec_carry_r  <= 1'b0;
            min_carry_r  <= 1'b0;
            day_pulse_r  <= 1'b0;
            cap_hour_r   <= 8'h00;
            cap_min_r    <= 8'h00;
            cap_sec_r    <= 8'h00;
        end else begin
            load_ok_r   <= 1'b0;
            load_err_r  <= 1'b0;
            sec_carry_r <= 1'b0;
            min_carry_r <= 1'b0;
            day_pulse_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    state_r      <= ST_RUN;
                    load_ready_r <= 1'b1;
                end
                ST_RUN: begin
                    // A handshake takes priority and swallows a coincident tick.
                    if (handshake_s) begin
                        cap_hour_r   <= load_hour;
                        cap_min_r    <= load_min;
                        cap_sec_r    <= load_sec;
                        state_r      <= ST_CHECK;
                        load_ready_r <= 1'b0;
                    end else if (tick && !hold) begin
                        sec_r       <= sec_next_s;
                        min_r       <= min_next_s;
                        hour_r      <= hour_next_s;
                        sec_carry_r <= sec_wrap_s;
                        min_carry_r <= min_wrap_s;
                        day_pulse_r <= hour_wrap_s;
                    end
                end
                ST_CHECK: begin
                    if (cap_ok_s) begin
                        sec_r     <= cap_sec_r;
                        min_r     <= cap_min_r;
                        hour_r    <= cap_hour_r;
                        load_ok_r <= 1'b1;
                    end else begin
                        load_err_r <= 1'b1;
                    end
                    state_r      <= ST_RUN;
                    load_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_INIT;
                    load_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign load_ok    = load_ok_r;
    assign load_err   = load_err_r;
    assign sec_bcd    = sec_r;
    assign min_bcd    = min_r;
    assign hour_bcd   = hour_r;
    assign sec_carry  = sec_carry_r;
    assign min_carry  = min_carry_r;
    assign day_pulse  = day_pulse_r;

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day core of the digital clock: it receives the one-cycle tick strobe produced by the counter/compare divider and turns it into seconds, minutes and hours. Time is held as BCD registers with rollover and carry strobes. A valid/ready load port lets the set-time logic write a new time, which is validated and committed atomically. Its outputs drive the display multiplexer and the alarm comparator.

## Interface
- HOURS_PER_DAY, default 24: hour wrap value, legal values 12 or 24. In 12 mode hours run 01..12; in 24 mode hours run 00..23.
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset rst, synchronous, active-high
- tick  input  1  one-cycle strobe, advance time by one second
- hold  input  1  while high, ticks are ignored and time is frozen
- load_valid  input  1  load request from set-time logic
- load_ready  output  1  block can accept a load this cycle
- load_hour  input  8  BCD hour {tens, units}
- load_min  input  8  BCD minute
- load_sec  input  8  BCD second
- load_ok  output  1  one-cycle pulse: load committed
- load_err  output  1  one-cycle pulse: load rejected, time unchanged
- sec_bcd  output  8  current seconds, BCD
- min_bcd  output  8  current minutes, BCD
- hour_bcd  output  8  current hours, BCD
- sec_carry  output  1  one-cycle pulse on 59->00 seconds
- min_carry  output  1  one-cycle pulse on 59->00 minutes
- day_pulse  output  1  one-cycle pulse on hour wrap (23->00, or 12->01 in 12 mode)

## Operation
- The FSM has three states.
  - INIT: entered on rst. Goes to RUN after one cycle unconditionally.
  - RUN: counts ticks and offers the load port. Goes to CHECK on handshake.
  - CHECK: lasts one cycle, then returns to RUN.
- rst is high on an edge: state goes to INIT.
  - Time registers reset to 00:00:00 in 24 mode, or 12:00:00 in 12 mode.
  - load_ready, load_ok, load_err and all carry pulses are 0.
  - rst overrides everything, including an in-flight CHECK.
- load_ready is 1 only in RUN.
- Handshake: a transfer occurs on an edge where load_valid=1 and load_ready=1.
  - load_hour/min/sec are captured into a holding register on that edge.
  - The source may change them afterwards.
- CHECK validation rules:
  - Every nibble must be 0..9.
  - Seconds and minutes tens nibble must be ≤5.
  - Hours must be 00..23 in 24 mode, or 01..12 in 12 mode.
- CHECK exit edge:
  - Pass: time registers take the captured value and load_ok=1 for one cycle.
  - Fail: time is unchanged and load_err=1 for one cycle.
- Ticks at the handshake edge and during CHECK are discarded, whether the load passes or fails.
- Counting happens in RUN, on an edge where tick=1, hold=0 and no handshake occurs.
  - Units increment; at 9 the units go to 0 and the tens increment.
  - Seconds and minutes wrap 59->00.
  - Minutes advance only when seconds wrap; hours advance only when minutes wrap.
  - 24 mode: hours wrap 23->00.
  - 12 mode: hours go 09->10, then 12->01.
- Carry strobes are registered.
  - Each is high in exactly the cycle in which the wrapped value first appears.
  - They cascade in the same cycle: 23:59:59 + tick gives sec_carry, min_carry and day_pulse together, with time 00:00:00.
- hold=1 ignores ticks but still allows loads.

## Timing
- Tick at edge N: updated time and carry pulses are visible after edge N (one-cycle latency). There is no combinational path from tick to outputs.
- Load accepted at edge N:
  - load_ready=0 after N.
  - New time and load_ok/load_err appear after edge N+1.
  - load_ready returns to 1 after N+1, so back-to-back loads are possible every 2 cycles.
- After rst deasserts at edge R, load_ready=1 after edge R+1 (INIT lasts one cycle).
- Ticks must be at least 1 cycle apart. Consecutive tick cycles each count.
- load_ok and load_err are never high together.

## Test plan
- Reset: rst for 2 cycles with tick=1 -> time 00:00:00, all strobes 0, load_ready=0 then 1 one cycle after release.
- Rollover cascade: load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with sec_carry, min_carry and day_pulse high for exactly 1 cycle.
- Valid load with competing tick: load 12:34:56 with tick=1 at the handshake edge and in CHECK -> load_ok pulse, time exactly 12:34:56, load_ready low for 1 cycle.
- Invalid loads: from 01:02:03, load hour 24, then min 0x60, then sec 0x0A -> three load_err pulses, time stays 01:02:03.
- Hold: with hold=1, 10 ticks -> time unchanged. Release hold, 1 tick -> +1 second.
- 12-hour build (HOURS_PER_DAY=12): load 12:59:59, 1 tick -> 01:00:00 with day_pulse. Loading hour 00 -> load_err.
